// File: rtl/record_play_control.sv
// Record/playback sequencer: button press -> Timer start + sample capture into RAM,
// and playback of exactly the recorded length. LOOP_PLAYBACK_EN enables looped playback.
module record_play_control #(
  parameter int unsigned SAMPLE_W     = 16,
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                record_btn,
  input  logic                play_btn,
  input  logic                sample_tick,
  input  logic [SAMPLE_W-1:0] mic_sample,
  input  logic                timer_finished,
  output logic                timer_start,
  output logic                mem_we,
  output logic                mem_re,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [SAMPLE_W-1:0] mem_wdata,
  input  logic [SAMPLE_W-1:0] mem_rdata,
  output logic [SAMPLE_W-1:0] audio_out,
  output logic                audio_out_valid,
  output logic                recording,
  output logic                playing,
  output logic [ADDR_W:0]     rec_len
);

  localparam int unsigned LEN_W   = ADDR_W + 1;
  localparam int unsigned GUARD_W = 8;
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {IDLE, RECORD_ARM, RECORD, PLAY} state_t;

  state_t              state;
  logic [2:0]          rec_sync;
  logic [2:0]          play_sync;
  logic                rec_press;
  logic                play_press;
  logic [ADDR_W-1:0]   addr;
  logic [GUARD_W-1:0]  guard;
  logic                play_done;
  logic                re_last;
  logic                rd_pending;
  logic                rd_last;
  logic                last_read;

  // [0] metastability flop, [1] synchronised level, [2] previous level
  assign rec_press  = rec_sync[1] & ~rec_sync[2];
  assign play_press = play_sync[1] & ~play_sync[2];
  assign last_read  = (LEN_W'(addr) + LEN_W'(1)) == rec_len;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      rec_sync        <= '0;
      play_sync       <= '0;
      addr            <= '0;
      guard           <= '0;
      play_done       <= 1'b0;
      re_last         <= 1'b0;
      rd_pending      <= 1'b0;
      rd_last         <= 1'b0;
      timer_start     <= 1'b0;
      mem_we          <= 1'b0;
      mem_re          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      audio_out       <= '0;
      audio_out_valid <= 1'b0;
      recording       <= 1'b0;
      playing         <= 1'b0;
      rec_len         <= '0;
    end else begin
      rec_sync        <= {rec_sync[1:0], record_btn};
      play_sync       <= {play_sync[1:0], play_btn};
      timer_start     <= 1'b0;
      mem_we          <= 1'b0;
      mem_re          <= 1'b0;
      audio_out_valid <= 1'b0;
      re_last         <= 1'b0;

      // RAM data arrives one cycle after mem_re; capture it regardless of state
      rd_pending <= mem_re;
      rd_last    <= re_last;
      if (rd_pending) begin
        audio_out       <= mem_rdata;
        audio_out_valid <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (rec_press) begin
            state       <= RECORD_ARM;
            addr        <= '0;
            rec_len     <= '0;
            guard       <= GUARD_W'(GUARD_CYCLES);
            timer_start <= 1'b1;
            recording   <= 1'b1;
          end else if (play_press && rec_len != '0) begin
            state     <= PLAY;
            addr      <= '0;
            play_done <= 1'b0;
            playing   <= 1'b1;
          end
        end

        RECORD_ARM, RECORD: begin
          if (rec_press) begin
            state     <= IDLE;
            recording <= 1'b0;
          end else if (state == RECORD && timer_finished) begin
            state     <= IDLE;
            recording <= 1'b0;
          end else begin
            if (sample_tick) begin
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= mic_sample;
              addr      <= addr + ADDR_W'(1);
              rec_len   <= rec_len + LEN_W'(1);
            end
            if (sample_tick && addr == ADDR_LAST) begin
              state     <= IDLE;
              recording <= 1'b0;
            end else if (state == RECORD_ARM) begin
              guard <= guard - GUARD_W'(1);
              if (guard == GUARD_W'(1)) state <= RECORD;
            end
          end
        end

        PLAY: begin
          if (rec_press) begin
            state       <= RECORD_ARM;
            addr        <= '0;
            rec_len     <= '0;
            guard       <= GUARD_W'(GUARD_CYCLES);
            timer_start <= 1'b1;
            recording   <= 1'b1;
            playing     <= 1'b0;
          end else if (play_press) begin
            state   <= IDLE;
            playing <= 1'b0;
          end else if (rd_last) begin
            state   <= IDLE;
            playing <= 1'b0;
          end else if (sample_tick && !play_done) begin
            mem_re   <= 1'b1;
            mem_addr <= addr;
            if (last_read) begin
`ifdef LOOP_PLAYBACK_EN
              addr <= '0;
`else
              play_done <= 1'b1;
              re_last   <= 1'b1;
`endif
            end else begin
              addr <= addr + ADDR_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_record_play_control.sv
// Directed bench for record_play_control with a transaction-level reference model
// checked every cycle, plus literal expectations per scenario.
module tb_record_play_control;

  localparam int unsigned SW    = 16;
  localparam int unsigned AW    = 6;
  localparam int          DEPTH = 1 << AW;
  localparam int          GUARD = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          record_btn = 1'b0;
  logic          play_btn = 1'b0;
  logic          sample_tick = 1'b0;
  logic          timer_finished = 1'b1;
  logic [SW-1:0] mic_sample = '0;
  logic [SW-1:0] mem_rdata = '0;
  logic          timer_start, mem_we, mem_re, audio_out_valid, recording, playing;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wdata, audio_out;
  logic [AW:0]   rec_len;

  record_play_control #(.SAMPLE_W(SW), .ADDR_W(AW), .GUARD_CYCLES(GUARD)) dut (
    .clock(clock), .reset_n(reset_n), .record_btn(record_btn), .play_btn(play_btn),
    .sample_tick(sample_tick), .mic_sample(mic_sample), .timer_finished(timer_finished),
    .timer_start(timer_start), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .audio_out(audio_out),
    .audio_out_valid(audio_out_valid), .recording(recording), .playing(playing),
    .rec_len(rec_len)
  );

  always #5 clock = ~clock;

  // Sample RAM: synchronous write, registered read
  logic [SW-1:0] ram [DEPTH];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: recorder described as "capturing"/"playing" activities and a
  // queue of playback samples due for delivery two cycles after each read.
  typedef struct { int due; logic [SW-1:0] data; bit last; } rd_t;
  rd_t           dq[$];
  logic [SW-1:0] mdl_mem [DEPTH];
  bit            m_rec = 0, m_play = 0, pdone = 0, rb_last = 0, pb_last = 0;
  bit            rp, pp, fin, lastrd;
  int            arm_left = 0, waddr = 0, raddr = 0, m_len = 0, mcyc = 0;
  int            rec_due = -1, play_due = -1;
  logic          e_ts = 0, e_we = 0, e_re = 0, e_av = 0;
  logic [AW-1:0] e_addr = '0;
  logic [SW-1:0] e_wdata = '0, e_audio = '0;
`ifdef LOOP_PLAYBACK_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  task automatic mdl_start_rec();
    e_ts = 1; m_rec = 1; m_play = 0; arm_left = GUARD; waddr = 0; m_len = 0;
  endtask

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      m_rec = 0; m_play = 0; pdone = 0; rb_last = 0; pb_last = 0;
      arm_left = 0; waddr = 0; raddr = 0; m_len = 0; rec_due = -1; play_due = -1;
      e_ts = 0; e_we = 0; e_re = 0; e_av = 0; e_addr = '0; e_wdata = '0; e_audio = '0;
      dq.delete();
    end else begin
      mcyc++;
      rp = (mcyc == rec_due);
      pp = (mcyc == play_due);
      // a button rising edge becomes a press two clock edges later
      if (record_btn && !rb_last) rec_due = mcyc + 2;
      if (play_btn && !pb_last) play_due = mcyc + 2;
      rb_last = record_btn; pb_last = play_btn;
      e_ts = 0; e_we = 0; e_re = 0; e_av = 0; fin = 0;
      if (dq.size() > 0 && dq[0].due == mcyc) begin
        e_av = 1; e_audio = dq[0].data; fin = dq[0].last;
        void'(dq.pop_front());
      end
      if (m_play) begin
        if (rp) mdl_start_rec();
        else if (pp || fin) m_play = 0;
        else if (sample_tick && !pdone) begin
          e_re = 1; e_addr = AW'(raddr);
          lastrd = (raddr + 1 == m_len);
          dq.push_back('{mcyc + 2, mdl_mem[raddr], lastrd && !LOOP});
          if (lastrd) begin
            if (LOOP) raddr = 0; else pdone = 1;
          end else raddr++;
        end
      end else if (m_rec) begin
        if (rp) m_rec = 0;
        else if (arm_left == 0 && timer_finished) m_rec = 0;
        else begin
          if (sample_tick) begin
            e_we = 1; e_addr = AW'(waddr); e_wdata = mic_sample;
            mdl_mem[waddr] = mic_sample; m_len++;
            if (waddr == DEPTH - 1) m_rec = 0;
            waddr = (waddr + 1) % DEPTH;
          end
          if (arm_left > 0) arm_left--;
        end
      end else begin
        if (rp) mdl_start_rec();
        else if (pp && m_len != 0) begin m_play = 1; raddr = 0; pdone = 0; end
      end
    end
  end

  int n_ts = 0, n_we = 0, n_re = 0, n_av = 0, last_waddr = 0, last_raddr = 0;

  // Per-cycle compare against the model, mid-cycle
  initial forever begin
    @(negedge clock);
    check("timer_start", timer_start, e_ts);
    check("mem_we", mem_we, e_we);
    check("mem_re", mem_re, e_re);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("audio_out_valid", audio_out_valid, e_av);
    check("audio_out", audio_out, e_audio);
    check("recording", recording, m_rec);
    check("playing", playing, m_play);
    check("rec_len", rec_len, m_len);
    check("we_re_exclusive", mem_we & mem_re, 0);
    if (timer_start === 1'b1) n_ts++;
    if (mem_we === 1'b1) begin n_we++; last_waddr = int'(mem_addr); end
    if (mem_re === 1'b1) begin n_re++; last_raddr = int'(mem_addr); end
    if (audio_out_valid === 1'b1) n_av++;
  end

  // Stimulus environment: Timer behaviour (0 normal, 1 stuck high, 2 stuck low) and ticks
  int tmode = 0, tf_cnt = 0, tf_low = 500, tick_per = 0, tick_ctr = 0;

  task automatic step();
    @(negedge clock);
    #1;
    case (tmode)
      0: begin
        if (timer_start) tf_cnt = tf_low;
        timer_finished = (tf_cnt == 0);
        if (tf_cnt > 0) tf_cnt--;
      end
      1: timer_finished = 1'b1;
      default: timer_finished = 1'b0;
    endcase
    if (tick_per > 0) begin
      sample_tick = (tick_ctr == 0);
      tick_ctr = (tick_ctr + 1) % tick_per;
    end else begin
      sample_tick = 1'b0;
    end
    mic_sample = SW'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic press(input bit r, input bit p);
    record_btn = r; play_btn = p;
    run(4);
    record_btn = 0; play_btn = 0;
    run(4);
  endtask

  int b_ts, b_we, b_re, b_av;

  initial begin
    run(3);
    reset_n = 1'b1;
    run(3);
    check("rst_rec_len", rec_len, 0);
    check("rst_recording", recording, 0);
    check("rst_mem_addr", mem_addr, 0);

    // Reset in the middle of a recording at address 37
    tmode = 0; tick_per = 3; tick_ctr = 0;
    press(1, 0);
    for (int i = 0; i < 400 && m_len < 37; i++) step();
    check("t1_rec_len_pre", rec_len, 37);
    check("t1_mem_addr_pre", mem_addr, 36);
    #2 reset_n = 1'b0;
    #1;
    check("t1_recording", recording, 0);
    check("t1_playing", playing, 0);
    check("t1_rec_len", rec_len, 0);
    check("t1_mem_we", mem_we, 0);
    check("t1_mem_addr", mem_addr, 0);
    check("t1_mem_wdata", mem_wdata, 0);
    check("t1_timer_start", timer_start, 0);
    check("t1_audio_out", audio_out, 0);
    run(2);
    reset_n = 1'b1; tf_cnt = 0;
    run(2);

    // 2 s recording cut off by the Timer: 50 ticks at period 10 within 500 cycles
    tick_per = 10; tick_ctr = 0; b_ts = n_ts; b_we = n_we;
    press(1, 0);
    run(560);
    check("t2_timer_pulses", n_ts - b_ts, 1);
    check("t2_writes", n_we - b_we, 50);
    check("t2_last_addr", last_waddr, 49);
    check("t2_rec_len", rec_len, 50);
    check("t2_mdl_len", m_len, 50);
    check("t2_idle", recording, 0);

    // Playback of the 50-sample recording
    b_re = n_re; b_av = n_av;
    press(0, 1);
    run(540);
`ifdef LOOP_PLAYBACK_EN
    check("t4_loop_rereads", (n_re - b_re) > 50, 1);
    check("t4_loop_playing", playing, 1);
    press(0, 1);
    run(4);
    check("t4_loop_stopped", playing, 0);
`else
    check("t4_reads", n_re - b_re, 50);
    check("t4_valids", n_av - b_av, 50);
    check("t4_last_raddr", last_raddr, 49);
    check("t4_playing_dropped", playing, 0);
`endif

    // Timer stuck high, no ticks: nothing recorded, play ignored
    tmode = 1; tick_per = 0; b_ts = n_ts; b_we = n_we;
    press(1, 0);
    run(20);
    check("t5_timer_pulses", n_ts - b_ts, 1);
    check("t5_no_writes", n_we - b_we, 0);
    check("t5_rec_len", rec_len, 0);
    check("t5_idle", recording, 0);
    b_re = n_re;
    press(0, 1);
    run(20);
    check("t5_play_ignored", n_re - b_re, 0);
    check("t5_not_playing", playing, 0);

    // Timer stuck high, tick every cycle: only the guard window is written
    tick_per = 1; tick_ctr = 0; b_we = n_we;
    press(1, 0);
    run(20);
    check("t5_guard_writes", n_we - b_we, 4);
    check("t5_guard_len", rec_len, 4);
    check("t5_guard_last", last_waddr, 3);
    check("t5_guard_idle", recording, 0);

    // Record+play pressed together during playback: recording restarts
    tmode = 0; tick_per = 10; tick_ctr = 0;
    press(0, 1);
    run(6);
    check("t6_playing", playing, 1);
    tick_per = 0; b_ts = n_ts;
    record_btn = 1; play_btn = 1;
    run(3);
    check("t6_timer_start", timer_start, 1);
    check("t6_recording", recording, 1);
    check("t6_playing_off", playing, 0);
    check("t6_rec_len", rec_len, 0);
    run(1);
    record_btn = 0; play_btn = 0;
    run(4);
    check("t6_timer_pulses", n_ts - b_ts, 1);

    // Abort, then fill the RAM with the Timer held low
    tmode = 2; tick_per = 2; tick_ctr = 0;
    press(1, 0);
    run(6);
    check("t3_aborted", recording, 0);
    b_we = n_we;
    press(1, 0);
    run(64 * 2 + 30);
    check("t3_writes", n_we - b_we, 64);
    check("t3_last_addr", last_waddr, 63);
    check("t3_rec_len", rec_len, 64);
    check("t3_mdl_len", m_len, 64);
    check("t3_idle", recording, 0);

    // Playback of a full RAM
    b_re = n_re;
    press(0, 1);
    run(64 * 2 + 20);
`ifdef LOOP_PLAYBACK_EN
    check("t3_loop_playing", playing, 1);
    press(0, 1);
    run(4);
    check("t3_loop_stopped", playing, 0);
`else
    check("t3_reads", n_re - b_re, 64);
    check("t3_last_raddr", last_raddr, 63);
    check("t3_playing_dropped", playing, 0);
`endif
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
